r2sdf_reorder: RTL

Streaming reorder buffer placed directly after an R2Sdf FFT pipeline. It converts the bit-reversed output frames into natural order, so downstream blocks stop doing index reversal. It is parametrised in maximum transform size, and the frame length is selectable at run time. It adds a sync-error detector and an output-valid flag, which the bare pipeline does not provide.

---
 rtl/r2sdf_reorder_pkg.sv | 27 ++
 rtl/r2sdf_reorder_dpram.sv | 29 ++
 rtl/r2sdf_reorder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/r2sdf_reorder_pkg.sv
// Shared types and index helpers for the R2SDF output reorder buffer.
package r2sdf_reorder_pkg;

  localparam int WL = 16;

  typedef struct packed {
    logic signed [WL-1:0] re;
    logic signed [WL-1:0] im;
  } Cplx;

  function automatic int clamp_stg(input int s, input int lo, input int hi);
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

  // Reverses only the low nstg bits of idx; every bit above them is zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nstg);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nstg) r[i] = idx[nstg-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/r2sdf_reorder_dpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port, both gated by en.
module r2sdf_reorder_dpram
  import r2sdf_reorder_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  Cplx           wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output Cplx           rdata
);

  Cplx mem [0:2**AW-1];
  Cplx rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/r2sdf_reorder.sv
// Ping-pong reorder buffer turning bit-reversed R2SDF frames into natural order,
// with run-time frame length, output-valid/sync flags and a misplaced-isync detector.
module r2sdf_reorder
  import r2sdf_reorder_pkg::*;
#(
  parameter int MAX_STG = 10,
  parameter int MIN_STG = 2,
  localparam int STG_W  = $clog2(MAX_STG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [STG_W-1:0] stg,
  input  Cplx              in,
  input  logic             isync,
  output Cplx              out,
  output logic             ovalid,
  output logic             osync,
  output logic             err
);

  localparam int AW = MAX_STG;

  function automatic logic [AW-1:0] last_idx(input logic [STG_W-1:0] s);
    return AW'((32'd1 << s) - 32'd1);
  endfunction

  logic [AW-1:0]    wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [STG_W-1:0] wstg_q, wstg_d, rstg_q, rstg_d, pstg_q, pstg_d, cur_wstg;
  logic             wbank_q, wbank_d, rbank_q, rbank_d, pbank_q, pbank_d;
  logic             ractive_q, ractive_d, pend_q, pend_d;
  logic             rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic             ovalid_q, ovalid_d, osync_q, osync_d, err_q, err_d;
  Cplx              out_q, out_d, ram_rdata;
  logic             wlast, rlast, rd_free;
  logic [AW:0]      waddr, raddr;

  always_comb begin
    cur_wstg = (wcnt_q == '0) ? STG_W'(clamp_stg(int'(stg), MIN_STG, MAX_STG)) : wstg_q;
    wlast    = (wcnt_q == last_idx(cur_wstg));
    wstg_d   = cur_wstg;
    wcnt_d   = (wlast || isync) ? '0 : wcnt_q + AW'(1);
    wbank_d  = wbank_q ^ wlast;
    err_d    = isync && !wlast;
    waddr    = {wbank_q, AW'(bitrev(32'(wcnt_q), int'(cur_wstg)))};

    rlast      = ractive_q && (rcnt_q == last_idx(rstg_q));
    rd_free    = !ractive_q || rlast;
    raddr      = {rbank_q, rcnt_q};
    rd_valid_d = ractive_q;
    rd_last_d  = rlast;
    ractive_d  = ractive_q && !rlast;
    rcnt_d     = ractive_q ? rcnt_q + AW'(1) : rcnt_q;
    rbank_d    = rbank_q;
    rstg_d     = rstg_q;
    pend_d     = pend_q;
    pbank_d    = pbank_q;
    pstg_d     = pstg_q;

    // A frame that completes while the reader is busy waits in one pending slot.
    // If a newer frame completes before it could start, its bank is about to be
    // rewritten, so the newer frame takes precedence and the stale one is dropped.
    if (rd_free) begin
      if (wlast) begin
        ractive_d = 1'b1;
        rcnt_d    = '0;
        rbank_d   = wbank_q;
        rstg_d    = cur_wstg;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        ractive_d = 1'b1;
        rcnt_d    = '0;
        rbank_d   = pbank_q;
        rstg_d    = pstg_q;
        pend_d    = 1'b0;
      end
    end else if (wlast) begin
      pend_d  = 1'b1;
      pbank_d = wbank_q;
      pstg_d  = cur_wstg;
    end

    out_d    = rd_valid_q ? ram_rdata : out_q;
    ovalid_d = rd_valid_q;
    osync_d  = rd_valid_q && rd_last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q     <= '0;
      wstg_q     <= '0;
      wbank_q    <= 1'b0;
      rcnt_q     <= '0;
      rstg_q     <= '0;
      rbank_q    <= 1'b0;
      ractive_q  <= 1'b0;
      pend_q     <= 1'b0;
      pbank_q    <= 1'b0;
      pstg_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      out_q      <= '0;
      ovalid_q   <= 1'b0;
      osync_q    <= 1'b0;
      err_q      <= 1'b0;
    end else if (en) begin
      wcnt_q     <= wcnt_d;
      wstg_q     <= wstg_d;
      wbank_q    <= wbank_d;
      rcnt_q     <= rcnt_d;
      rstg_q     <= rstg_d;
      rbank_q    <= rbank_d;
      ractive_q  <= ractive_d;
      pend_q     <= pend_d;
      pbank_q    <= pbank_d;
      pstg_q     <= pstg_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      out_q      <= out_d;
      ovalid_q   <= ovalid_d;
      osync_q    <= osync_d;
      err_q      <= err_d;
    end
  end

  r2sdf_reorder_dpram #(.AW(AW + 1)) u_ram (
    .clk   (clk),
    .en    (en),
    .we    (1'b1),
    .waddr (waddr),
    .wdata (in),
    .re    (ractive_q),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  assign out    = out_q;
  assign ovalid = ovalid_q;
  assign osync  = osync_q;
  assign err    = err_q;

endmodule
